// File: rtl/module_led_ctrl.sv
// module_led_ctrl: shows decoded Hamming words on LEDs; LED_ERR_BLINK_EN adds data/syndrome alternation
module module_led_ctrl #(
  parameter int PERIOD = 13500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       datos_valid,
  input  logic [3:0] datos_out,
  input  logic [2:0] sindrome,
  output logic       ack,
  output logic [3:0] leds,
  output logic       err
);
`ifdef LED_ERR_BLINK_EN
  typedef enum logic [1:0] {IDLE, SHOW_DATA, SHOW_SYN} state_e;
  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE, SHOW_DATA} state_e;
`endif
  state_e     state_q, state_d;
  logic [3:0] data_q, data_d;
  logic [2:0] syn_q, syn_d;
  logic       ack_q, ack_d;
  logic [3:0] leds_q, leds_d;
  logic       err_q, err_d;
  if (PERIOD < 2) begin : g_bad_period
    $error("PERIOD must be at least 2");
  end
  // next state; outputs are derived from the next state so they register on the same edge
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    syn_d   = syn_q;
    ack_d   = 1'b0;
`ifdef LED_ERR_BLINK_EN
    cnt_d   = cnt_q;
`endif
    if (clr) begin
      state_d = IDLE;
      data_d  = '0;
      syn_d   = '0;
`ifdef LED_ERR_BLINK_EN
      cnt_d   = '0;
`endif
    end else if (datos_valid) begin
      state_d = SHOW_DATA;
      data_d  = datos_out;
      syn_d   = sindrome;
      ack_d   = 1'b1;
`ifdef LED_ERR_BLINK_EN
      cnt_d   = '0;
`endif
    end
`ifdef LED_ERR_BLINK_EN
    else if (state_q != IDLE && syn_q != 3'd0) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = (state_q == SHOW_DATA) ? SHOW_SYN : SHOW_DATA;
    end
    leds_d = (state_d == IDLE) ? 4'b0000 : (state_d == SHOW_SYN) ? {1'b1, syn_d} : data_d;
`else
    leds_d = (state_d == IDLE) ? 4'b0000 : data_d;
`endif
    err_d = |syn_d;
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      syn_q   <= '0;
      ack_q   <= 1'b0;
      leds_q  <= '0;
      err_q   <= 1'b0;
`ifdef LED_ERR_BLINK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      syn_q   <= syn_d;
      ack_q   <= ack_d;
      leds_q  <= leds_d;
      err_q   <= err_d;
`ifdef LED_ERR_BLINK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign ack  = ack_q;
  assign leds = leds_q;
  assign err  = err_q;
endmodule

// File: tb/tb_module_led_ctrl.sv
// tb_module_led_ctrl: directed checks of module_led_ctrl with PERIOD=4
module tb_module_led_ctrl;
`ifdef LED_ERR_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       datos_valid = 1'b0;
  logic [3:0] datos_out = '0;
  logic [2:0] sindrome = '0;
  logic       ack;
  logic [3:0] leds;
  logic       err;
  int total = 0;
  int bad = 0;
  module_led_ctrl #(.PERIOD(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .datos_valid(datos_valid),
    .datos_out(datos_out), .sindrome(sindrome), .ack(ack), .leds(leds), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input logic [3:0] d, input logic [2:0] s);
    datos_valid = 1'b1;
    datos_out = d;
    sindrome = s;
  endtask
  function automatic logic [3:0] blink_exp(input int k);
    return (BLINK && ((k / 4) % 2 == 1)) ? 4'b1101 : 4'b0110;
  endfunction
  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_leds", leds, 4'b0000);
    chk("rst_ack", {3'b0, ack}, 4'd0);
    chk("rst_err", {3'b0, err}, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_leds", leds, 4'b0000);
    send(4'b1010, 3'b000);
    step();
    datos_valid = 1'b0;
    chk("w1_leds", leds, 4'b1010);
    chk("w1_ack", {3'b0, ack}, 4'd1);
    chk("w1_err", {3'b0, err}, 4'd0);
    step();
    chk("w1_ack_drop", {3'b0, ack}, 4'd0);
    for (int i = 0; i < 20; i++) begin
      chk("w1_hold", leds, 4'b1010);
      step();
    end
    send(4'b0110, 3'b101);
    step();
    datos_valid = 1'b0;
    chk("w2_ack", {3'b0, ack}, 4'd1);
    for (int k = 0; k < 14; k++) begin
      chk("w2_leds", leds, blink_exp(k));
      chk("w2_err", {3'b0, err}, 4'd1);
      step();
    end
    chk("w2_before_w3", leds, blink_exp(14));
    send(4'b0011, 3'b000);
    step();
    datos_valid = 1'b0;
    chk("w3_leds", leds, 4'b0011);
    chk("w3_ack", {3'b0, ack}, 4'd1);
    chk("w3_err", {3'b0, err}, 4'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("w3_hold", leds, 4'b0011);
    end
    send(4'b0001, 3'b000);
    step();
    chk("b2b_ack1", {3'b0, ack}, 4'd1);
    chk("b2b_leds1", leds, 4'b0001);
    send(4'b0010, 3'b011);
    step();
    datos_valid = 1'b0;
    chk("b2b_ack2", {3'b0, ack}, 4'd1);
    chk("b2b_leds2", leds, 4'b0010);
    chk("b2b_err2", {3'b0, err}, 4'd1);
    clr = 1'b1;
    send(4'b1111, 3'b001);
    step();
    clr = 1'b0;
    datos_valid = 1'b0;
    chk("clr_leds", leds, 4'b0000);
    chk("clr_ack", {3'b0, ack}, 4'd0);
    chk("clr_err", {3'b0, err}, 4'd0);
    step();
    chk("clr_idle", leds, 4'b0000);
    send(4'b0110, 3'b101);
    step();
    datos_valid = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    chk("pre_rst_leds", leds, blink_exp(5));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_leds", leds, 4'b0000);
    chk("async_rst_err", {3'b0, err}, 4'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_idle", leds, 4'b0000);
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    send(4'b1001, 3'b000);
    step();
    datos_valid = 1'b0;
    chk("after_rst_leds", leds, 4'b1001);
    chk("after_rst_ack", {3'b0, ack}, 4'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/module_led_ctrl.md
MODULE_LED_CTRL -- requirements
Module: module_led_ctrl

Interface
REQ-001 Parameter PERIOD, default 13500000, number of clk cycles each display phase lasts (0.5 s at 27 MHz); legal range 2 or more.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-high.
REQ-004 clr  input  1  synchronous clear of displayed word; returns block to IDLE.
REQ-005 datos_valid  input  1  single-cycle pulse marking a new corrected word from the Hamming decoder.
REQ-006 datos_out  input  4  corrected data word; sampled only when datos_valid=1.
REQ-007 sindrome  input  3  decoder syndrome (error bit position); 0 means no error; sampled with datos_out.
REQ-008 ack  output  1  one-cycle acknowledge of an accepted word.
REQ-009 leds  output  4  registered LED drive.
REQ-010 err  output  1  high while the latched syndrome is non-zero.

Function
REQ-011 FSM states SHALL be IDLE, SHOW_DATA and SHOW_SYN; all outputs registered.
REQ-012 IDLE: leds=0000, err=0; datos_valid=1 latches datos_out and sindrome, clears phase counter, moves to SHOW_DATA.
REQ-013 Latency: leds SHALL show the new word and ack SHALL be 1 at the first rising edge that samples datos_valid=1; ack SHALL be 0 on the following cycle unless another word is accepted.
REQ-014 SHOW_DATA: leds = latched data; if latched syndrome is 0, state is held indefinitely and the counter is held at 0.
REQ-015 SHOW_DATA with non-zero syndrome: counter counts 0..PERIOD-1; at PERIOD-1, counter wraps to 0 and state goes to SHOW_SYN. Each phase lasts exactly PERIOD cycles.
REQ-016 SHOW_SYN: leds = {1, latched syndrome}; at counter PERIOD-1, counter wraps to 0 and state goes to SHOW_DATA.
REQ-017 datos_valid in SHOW_DATA or SHOW_SYN SHALL be accepted every time: relatch, counter to 0, state to SHOW_DATA, ack pulse. No word is ever dropped.
REQ-018 Back-to-back datos_valid on consecutive cycles SHALL give ack high on consecutive cycles; the last word wins.
REQ-019 clr=1 SHALL force IDLE, counter 0, leds 0000, err 0 and ack 0 on the next edge. clr wins over a simultaneous datos_valid, and that word is not acknowledged.
REQ-020 Counter width SHALL be $clog2(PERIOD) bits; the counter never exceeds PERIOD-1.
REQ-021 err SHALL update on the same edge as the latched syndrome.

Reset
REQ-022 rst=1 SHALL immediately, without a clock edge, force IDLE, counter 0, leds 0000, ack 0, err 0, latched data and syndrome 0.
REQ-023 Reset asserted mid-phase SHALL abort the phase; after release, the block stays in IDLE until the next datos_valid.
REQ-024 datos_valid sampled on the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro LED_ERR_BLINK_EN: when defined, SHOW_SYN alternation per REQ-015 and REQ-016 is built.
REQ-026 When LED_ERR_BLINK_EN is undefined, SHOW_SYN and the phase counter SHALL be omitted. SHOW_DATA holds the data indefinitely regardless of syndrome, and err still reflects the syndrome.

Verification (PERIOD=4, LED_ERR_BLINK_EN defined unless noted)
REQ-027 Reset, then datos_valid with datos_out=1010 and sindrome=000 -> next edge: leds=1010, ack=1 for 1 cycle, err=0; leds stay 1010 for 20 cycles.
REQ-028 datos_valid with 0110/101 -> leds=0110 for 4 cycles, then 1101 for 4 cycles, then 0110 again; err=1 throughout.
REQ-029 During SHOW_SYN, datos_valid with 0011/000 -> next edge: leds=0011, ack=1, err=0; no further toggling.
REQ-030 clr and datos_valid (1111/001) asserted on the same cycle -> leds=0000, ack=0, state IDLE.
REQ-031 rst pulsed asynchronously mid-phase while leds=1101 -> leds=0000 before the next clk edge; IDLE held after release.
REQ-032 LED_ERR_BLINK_EN undefined, datos_valid with 0110/101 -> leds=0110 and err=1 for 20 cycles, no toggling.
